// File: rtl/vn_injection_scheduler.sv
// Shares one injection link among NUM_VN*NUM_VC channels: credit-aware rotating
// round-robin pick, then the link stays locked to the winner until its tail flit is sent.
module vn_injection_scheduler #(
  parameter int unsigned NUM_VC      = 1,
  parameter int unsigned NUM_VN      = 3,
  parameter int unsigned MAX_CREDITS = 4,
  localparam int unsigned N          = NUM_VC * NUM_VN,
  localparam int unsigned BITS_N     = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned BITS_CR    = $clog2(MAX_CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      tail_in,
  input  logic [N-1:0]      credit_in,
  input  logic              out_ready,
  output logic [N-1:0]      grant_vector,
  output logic [BITS_N-1:0] grant_id,
  output logic              flit_valid,
  output logic              busy,
  output logic              credit_ovf
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  state_t               next_state;
  logic [BITS_N-1:0]    owner;
  logic [BITS_N-1:0]    token;
  logic [BITS_N-1:0]    next_token;
  logic [BITS_CR-1:0]   credits      [N];
  logic [BITS_CR-1:0]   credits_next [N];
  logic [N-1:0]         elig;
  logic [N-1:0]         dec_vec;
  logic [N-1:0]         ovf_hit;
  logic                 send;
  logic                 grant_now;
  logic                 release_now;
  logic                 pick_found;
  logic [BITS_N-1:0]    pick_idx;
  int unsigned          cand;

  // Eligibility: a flit is waiting and the downstream buffer has room.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = req_in[i] & (credits[i] != '0);
    end
  end

  // Rotating-priority scan starting at token.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(token) + k) % N;
      if (!pick_found && elig[BITS_N'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = BITS_N'(cand);
      end
    end
  end

  assign flit_valid  = (state == LOCKED) & req_in[owner] & (credits[owner] != '0);
  assign send        = flit_valid & out_ready;
  assign grant_now   = (state == IDLE) & pick_found;
  assign release_now = (state == LOCKED) & send & tail_in[owner];
  assign next_token  = (owner == BITS_N'(N - 1)) ? '0 : owner + BITS_N'(1);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = LOCKED;
      LOCKED:  if (release_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Credit counters; a return into a full counter is dropped and flagged.
  always_comb begin
    credits_next = credits;
    dec_vec      = '0;
    ovf_hit      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dec_vec[i] = send & (owner == BITS_N'(i));
      if (dec_vec[i] && !credit_in[i]) begin
        credits_next[i] = credits[i] - BITS_CR'(1);
      end else if (credit_in[i] && !dec_vec[i]) begin
        if (credits[i] == BITS_CR'(MAX_CREDITS)) ovf_hit[i] = 1'b1;
        else                                      credits_next[i] = credits[i] + BITS_CR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      token        <= '0;
      grant_vector <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      credit_ovf   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) credits[i] <= BITS_CR'(MAX_CREDITS);
    end else begin
      state   <= next_state;
      credits <= credits_next;
      if (|ovf_hit) credit_ovf <= 1'b1;
      if (grant_now) begin
        owner        <= pick_idx;
        grant_id     <= pick_idx;
        grant_vector <= N'(1) << pick_idx;
        busy         <= 1'b1;
      end else if (release_now) begin
        token        <= next_token;
        grant_id     <= '0;
        grant_vector <= '0;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vn_injection_scheduler.sv
// Bench for vn_injection_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the scheduler.
module tb_vn_injection_scheduler;

  localparam int N    = 3;
  localparam int MAXC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_in;
  logic [N-1:0] tail_in;
  logic [N-1:0] credit_in;
  logic         out_ready;
  logic [N-1:0] grant_vector;
  logic [1:0]   grant_id;
  logic         flit_valid;
  logic         busy;
  logic         credit_ovf;

  int n_checks;
  int n_fail;

  // Model state
  int m_cr [N];
  int m_token;
  int m_owner;
  bit m_locked;
  bit m_ovf;

  vn_injection_scheduler #(.NUM_VC(1), .NUM_VN(3), .MAX_CREDITS(MAXC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .tail_in      (tail_in),
    .credit_in    (credit_in),
    .out_ready    (out_ready),
    .grant_vector (grant_vector),
    .grant_id     (grant_id),
    .flit_valid   (flit_valid),
    .busy         (busy),
    .credit_ovf   (credit_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_fv();
    return m_locked && req_in[m_owner] && (m_cr[m_owner] != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cr[i] = MAXC;
    m_token  = 0;
    m_owner  = 0;
    m_locked = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_gv;
    logic [31:0] exp_id;
    exp_gv = m_locked ? (32'd1 << m_owner) : 32'd0;
    exp_id = m_locked ? 32'(m_owner) : 32'd0;
    chk("grant_vector", 32'(grant_vector), exp_gv);
    chk("grant_id",     32'(grant_id),     exp_id);
    chk("busy",         32'(busy),         32'(m_locked));
    chk("flit_valid",   32'(flit_valid),   32'(m_fv()));
    chk("credit_ovf",   32'(credit_ovf),   32'(m_ovf));
  endtask

  // One clock of the scheduler's rules applied to the model.
  task automatic model_step();
    bit send;
    int own;
    own  = m_owner;
    send = m_fv() && out_ready;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_token + k) % N;
        if (req_in[i] && m_cr[i] != 0) begin
          m_locked = 1'b1;
          m_owner  = i;
          break;
        end
      end
    end else if (send && tail_in[own]) begin
      m_locked = 1'b0;
      m_token  = (own + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      int c;
      c = m_cr[i] - ((send && own == i) ? 1 : 0) + (credit_in[i] ? 1 : 0);
      if (c > MAXC) begin
        c     = MAXC;
        m_ovf = 1'b1;
      end
      m_cr[i] = c;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] t,
                     input logic [N-1:0] c, input logic rdy);
    req_in    = r;
    tail_in   = t;
    credit_in = c;
    out_ready = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic refill();
    for (int n = 0; n < MAXC + 1; n++) begin
      logic [N-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) if (m_cr[i] < MAXC) c[i] = 1'b1;
      cyc('0, '0, c, 1'b1);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    req_in    = '0;
    credit_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_in    = '1;
    tail_in   = '0;
    credit_in = '0;
    out_ready = 1'b1;
    model_reset();
    #7;
    check_outputs();
    req_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;

    // Credit readback on channel 0: four sends then stall, then finish with a returned credit
    repeat (7) cyc(3'b001, 3'b000, 3'b000, 1'b1);
    cyc(3'b001, 3'b001, 3'b001, 1'b1);
    cyc(3'b001, 3'b001, 3'b000, 1'b1);
    refill();

    // Round robin with single-flit packets
    repeat (9) cyc(3'b111, 3'b111, 3'b000, 1'b1);
    refill();

    // Packet lock on channel 1 while channel 0 keeps requesting
    cyc(3'b010, 3'b000, 3'b000, 1'b1);
    cyc(3'b011, 3'b000, 3'b000, 1'b1);
    cyc(3'b011, 3'b000, 3'b000, 1'b1);
    cyc(3'b011, 3'b010, 3'b000, 1'b1);
    repeat (3) cyc(3'b011, 3'b001, 3'b000, 1'b1);
    refill();

    // Credit stall on a 6-flit packet from channel 2
    repeat (7) cyc(3'b100, 3'b000, 3'b000, 1'b1);
    cyc(3'b100, 3'b000, 3'b100, 1'b1);
    cyc(3'b100, 3'b000, 3'b100, 1'b1);
    cyc(3'b100, 3'b100, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 3'b000, 1'b1);
    refill();

    // Send and return in the same cycle at credits=1, then overflow a full counter
    repeat (4) cyc(3'b001, 3'b000, 3'b000, 1'b1);
    cyc(3'b001, 3'b000, 3'b001, 1'b1);
    cyc(3'b001, 3'b001, 3'b000, 1'b1);
    cyc(3'b000, 3'b000, 3'b000, 1'b1);
    refill();
    cyc(3'b000, 3'b000, 3'b001, 1'b1);
    cyc(3'b000, 3'b000, 3'b000, 1'b1);

    // Reset while locked on channel 1, then arbitration restarts at token 0
    cyc(3'b010, 3'b000, 3'b000, 1'b1);
    cyc(3'b010, 3'b000, 3'b000, 1'b1);
    req_in = 3'b010;
    async_reset();
    repeat (4) cyc(3'b111, 3'b111, 3'b000, 1'b1);

    // Random traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] c;
      for (int i = 0; i < N; i++) c[i] = ($urandom_range(0, 7) == 0);
      if (n == 300) async_reset();
      cyc(N'($urandom), N'($urandom), c, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
